fsm_toggle_multi: RTL and testbench
===================================

# fsm_toggle_multi

Multi-channel, parametrised successor to the single-bit two-state toggling Moore FSM. Each of CH independent channels holds a one-bit state (A: dout=0, B: dout=1). A channel toggles only after its input has matched a programmable qualifying level for HOLD consecutive enabled cycles. Per-channel toggle pulses and saturating toggle counters are provided for status logic.

## Interface
- CH, default 4: number of independent channels (≥1).
- HOLD, default 1: consecutive qualifying cycles required to toggle (≥1). HOLD=1 gives the classic one-cycle toggle.
- RESET_STATE, default 1: state loaded on reset (1 = B, 0 = A), all channels.
- CNT_W, default 8: width of each per-channel toggle counter (≥1).

- clk  in  1  sole clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  global enable. 0 freezes all state, hold counters and toggle counters.
- tgl_level  in  1  qualifying input level. Default usage 0 (toggle when din=0).
- din  in  CH  per-channel data input.
- cnt_clr  in  1  synchronous clear of all toggle counters.
- dout  out  CH  per-channel state (Moore, registered).
- toggle_pulse  out  CH  one-cycle pulse, high in the cycle after a channel's state changed.
- toggle_count  out  CH*CNT_W  per-channel saturating toggle counts. Channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Per channel i, qualify_i = en & (din[i] == tgl_level), evaluated each rising edge with current input values.
- Hold counter h_i has width max(1, clog2(HOLD)) and resets to 0.
- On each rising edge, with reset high:
  - en=0: nothing changes. h_i, state, toggle_count hold. toggle_pulse goes to 0.
  - en=1, qualify_i=0: h_i := 0. State holds. toggle_pulse[i] := 0.
  - en=1, qualify_i=1, h_i < HOLD-1: h_i := h_i+1. State holds. toggle_pulse[i] := 0.
  - en=1, qualify_i=1, h_i == HOLD-1: state_i := ~state_i, h_i := 0, toggle_pulse[i] := 1, toggle_count_i increments.
- With HOLD=1, every qualifying enabled cycle toggles the channel (h_i stays 0).
- A change of tgl_level mid-streak is applied immediately. A sample that no longer qualifies clears h_i.
- toggle_count_i saturates at 2^CNT_W-1. A toggle at saturation leaves the count unchanged; the state and pulse still occur.
- cnt_clr=1 sets all counts to 0 on that edge. cnt_clr has priority over a simultaneous increment (result 0). cnt_clr works regardless of en. cnt_clr does not affect state, h_i or pulses.
- Channels are fully independent. Simultaneous toggles on any subset are legal.
- dout = state register directly. There is no combinational path from din, en or tgl_level to any output.

## Timing
- While reset=0, all outputs are forced immediately (no clock required):
  - dout = {CH{RESET_STATE}}
  - toggle_pulse = 0
  - toggle_count = 0
  - all h_i = 0
- Reset release is synchronous-safe: the first edge with reset=1 performs normal evaluation.
- Latency is HOLD edges. If din qualifies at sampling edges k … k+HOLD-1 (en=1), dout flips right after edge k+HOLD-1, and toggle_pulse is high for exactly that following cycle.
- Maximum toggle rate is one toggle per HOLD cycles per channel.
- Reset asserted mid-streak discards the partial hold count. Reset asserted mid-pulse cuts the pulse short immediately.

## Test plan
- Reset/defaults: CH=4, HOLD=1, RESET_STATE=1. Assert reset=0 between clock edges -> dout=4'b1111 and counts=0 immediately. Release, en=1, tgl_level=0, din=4'b1111 for 3 cycles -> dout stays 4'b1111 with no pulses.
- Legacy sequence on channel 0 (HOLD=1): din[0] = 1,0,0,0,1,1 -> dout[0] = 1,0,1,0,0,0 after successive edges. toggle_count_0 = 3, with a pulse in each toggling cycle.
- Hold qualification (HOLD=3, tgl_level=1): din[1] = 1,1,0,1,1,1 -> no toggle through the 5th edge; dout[1] flips after the 6th edge. toggle_pulse[1] is high for 1 cycle.
- Enable freeze: HOLD=3, two qualifying cycles, then en=0 for 4 cycles, then 1 qualifying cycle with en=1 -> toggle occurs on that edge, since the count was held rather than cleared.
- Counter saturation/clear: CNT_W=2, 5 toggles on channel 2 -> count sticks at 3. Drive cnt_clr=1 on the same edge as a toggle -> count=0 and dout[2] still flips.
- Async reset mid-operation: HOLD=3, after 2 qualifying cycles pulse reset low for 3 ns off-edge -> dout returns to RESET_STATE immediately. The next 2 qualifying cycles after release do not toggle; the 3rd does.

Source files
------------

// File: rtl/fsm_toggle_multi.sv
// fsm_toggle_multi
//   CH independent two-state toggling Moore channels. A channel flips its
//   state after its input has matched the qualifying level for HOLD
//   consecutive enabled cycles. Each channel also provides:
//     - a one-cycle toggle pulse
//     - a saturating toggle counter
//
// Parameters
//   CH          number of channels (>= 1)
//   HOLD        consecutive qualifying cycles needed to toggle (>= 1)
//   RESET_STATE state loaded on reset for every channel (1 = B, 0 = A)
//   CNT_W       width of each toggle counter (>= 1)
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   en            global enable; low freezes state, hold and toggle counters
//   tgl_level     input level that qualifies a sample
//   din           per-channel data input
//   cnt_clr       synchronous clear of all toggle counters (works regardless of en)
//   dout          per-channel state (registered)
//   toggle_pulse  per-channel pulse, high in the cycle after a state change
//   toggle_count  per-channel saturating count, channel i at [i*CNT_W +: CNT_W]
module fsm_toggle_multi #(
    parameter int CH          = 4,
    parameter int HOLD        = 1,
    parameter int RESET_STATE = 1,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                tgl_level,
    input  logic [CH-1:0]       din,
    input  logic                cnt_clr,
    output logic [CH-1:0]       dout,
    output logic [CH-1:0]       toggle_pulse,
    output logic [CH*CNT_W-1:0] toggle_count
);

    typedef enum logic {
        ST_A = 1'b0,
        ST_B = 1'b1
    } state_t;

    // Hold counter only needs to reach HOLD-1; keep at least one bit.
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]    H_MAX   = HW'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam state_t           RST_ST  = (RESET_STATE != 0) ? ST_B : ST_A;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t           state_r;
        logic [HW-1:0]    hold_r;
        logic             pulse_r;
        logic [CNT_W-1:0] cnt_r;
        logic             qualify_s;
        logic             fire_s;

        // Sample qualification and decide whether this edge completes a streak.
        always_comb begin
            qualify_s = en & (din[i] == tgl_level);
            if (qualify_s && (hold_r == H_MAX)) begin
                fire_s = 1'b1;
            end else begin
                fire_s = 1'b0;
            end
        end

        // Channel FSM with hold counter, toggle pulse and saturating counter.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_r <= RST_ST;
                hold_r  <= {HW{1'b0}};
                pulse_r <= 1'b0;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                if (en) begin
                    if (!qualify_s) begin
                        hold_r  <= {HW{1'b0}};
                        pulse_r <= 1'b0;
                    end else if (fire_s) begin
                        hold_r  <= {HW{1'b0}};
                        pulse_r <= 1'b1;
                        case (state_r)
                            ST_A:    state_r <= ST_B;
                            ST_B:    state_r <= ST_A;
                            default: state_r <= RST_ST;
                        endcase
                    end else begin
                        hold_r  <= hold_r + HW'(1);
                        pulse_r <= 1'b0;
                    end
                end else begin
                    // Frozen: state and hold count keep their values.
                    pulse_r <= 1'b0;
                end

                // Clear wins over a simultaneous increment; the count sticks at max.
                if (cnt_clr) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (fire_s && (cnt_r != CNT_MAX)) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end

        assign dout[i]                        = state_r;
        assign toggle_pulse[i]                = pulse_r;
        assign toggle_count[i*CNT_W +: CNT_W] = cnt_r;
    end

endmodule

// File: tb/tb_fsm_toggle_multi.sv
// Self-checking bench for fsm_toggle_multi. Three instances share one
// stimulus stream:
//   u1   HOLD=1, RESET_STATE=1, CNT_W=8
//   u3   HOLD=3, RESET_STATE=0, CNT_W=8
//   usat HOLD=1, RESET_STATE=1, CNT_W=2
// A streak-counting reference model predicts every output after every edge.
module tb_fsm_toggle_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       tgl_level;
    logic [3:0] din;
    logic       cnt_clr;

    logic [3:0]  d1, p1, d3, p3, ds, ps;
    logic [31:0] c1, c3;
    logic [7:0]  cs;
    logic [95:0] obs_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_toggle_multi #(.CH(4), .HOLD(1), .RESET_STATE(1), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .en(en), .tgl_level(tgl_level), .din(din),
        .cnt_clr(cnt_clr), .dout(d1), .toggle_pulse(p1), .toggle_count(c1));
    fsm_toggle_multi #(.CH(4), .HOLD(3), .RESET_STATE(0), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .en(en), .tgl_level(tgl_level), .din(din),
        .cnt_clr(cnt_clr), .dout(d3), .toggle_pulse(p3), .toggle_count(c3));
    fsm_toggle_multi #(.CH(4), .HOLD(1), .RESET_STATE(1), .CNT_W(2)) usat (
        .clk(clk), .reset(reset), .en(en), .tgl_level(tgl_level), .din(din),
        .cnt_clr(cnt_clr), .dout(ds), .toggle_pulse(ps), .toggle_count(cs));

    assign obs_s = {d1, p1, c1, d3, p3, c3, ds, ps, cs};

    // Reference model: per instance k, channel i
    int HOLDS[3] = '{1, 3, 1};
    int CMAX[3]  = '{255, 255, 3};
    int RSTV[3]  = '{1, 0, 1};
    int st[3][4];
    int streak[3][4];
    int pl[3][4];
    int cnt[3][4];

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                st[k][i] = RSTV[k]; streak[k][i] = 0; pl[k][i] = 0; cnt[k][i] = 0;
            end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                if (en) begin
                    if (din[i] == tgl_level) begin
                        streak[k][i] = streak[k][i] + 1;
                        if (streak[k][i] == HOLDS[k]) begin
                            st[k][i] = 1 - st[k][i];
                            streak[k][i] = 0;
                            pl[k][i] = 1;
                            if (cnt[k][i] < CMAX[k]) cnt[k][i] = cnt[k][i] + 1;
                        end else begin
                            pl[k][i] = 0;
                        end
                    end else begin
                        streak[k][i] = 0;
                        pl[k][i] = 0;
                    end
                end else begin
                    pl[k][i] = 0;
                end
                if (cnt_clr) cnt[k][i] = 0;
            end
    endtask

    function automatic logic [95:0] exp_all();
        logic [3:0]  d[3];
        logic [3:0]  p[3];
        logic [31:0] c[3];
        logic [7:0]  csx;
        for (int k = 0; k < 3; k++) begin
            c[k] = 32'd0;
            for (int i = 0; i < 4; i++) begin
                d[k][i] = (st[k][i] != 0);
                p[k][i] = (pl[k][i] != 0);
                c[k][i*8 +: 8] = 8'(cnt[k][i]);
            end
        end
        csx = 8'd0;
        for (int i = 0; i < 4; i++) csx[i*2 +: 2] = 2'(cnt[2][i]);
        return {d[0], p[0], c[0], d[1], p[1], c[1], d[2], p[2], csx};
    endfunction

    // Advance the model with the inputs present at the edge, then let the DUTs take it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [95:0] rst_exp;
        rst_exp = {4'hF, 4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 4'hF, 4'h0, 8'h0};
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checks++;
        if (obs_s !== rst_exp) begin
            $display("FAIL reset_immediate obs=%h exp=%h", obs_s, rst_exp); errors++;
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        en = 1'b1; tgl_level = 1'b0; din = 4'b1111; cnt_clr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (d1 !== 4'b1111 || p1 !== 4'b0000) begin
                $display("FAIL reset_idle cyc%0d dout=%b pulse=%b exp dout=1111 pulse=0000", n, d1, p1); errors++;
            end
            checks++;
            if (obs_s !== exp_all()) begin
                $display("FAIL reset_idle_model cyc%0d obs=%h exp=%h", n, obs_s, exp_all()); errors++;
            end
        end
    endtask

    task automatic test_legacy();
        logic [5:0] seq_v;
        logic [5:0] exp_d;
        logic [5:0] exp_p;
        seq_v = 6'b110001;  // din[0] = 1,0,0,0,1,1 (bit n is step n)
        exp_d = 6'b000101;  // dout[0] = 1,0,1,0,0,0
        exp_p = 6'b001110;  // pulse[0] = 0,1,1,1,0,0
        tgl_level = 1'b0;
        for (int n = 0; n < 6; n++) begin
            din = {3'b111, seq_v[n]};
            tick();
            checks++;
            if (d1[0] !== exp_d[n] || p1[0] !== exp_p[n]) begin
                $display("FAIL legacy step%0d dout0=%b pulse0=%b exp %b %b", n, d1[0], p1[0], exp_d[n], exp_p[n]); errors++;
            end
            checks++;
            if (obs_s !== exp_all()) begin
                $display("FAIL legacy_model step%0d obs=%h exp=%h", n, obs_s, exp_all()); errors++;
            end
        end
        checks++;
        if (c1[7:0] !== 8'd3) begin
            $display("FAIL legacy_count got=%0d exp=3", c1[7:0]); errors++;
        end
    endtask

    task automatic test_hold();
        logic [5:0] seq_v;
        logic       v;
        seq_v = 6'b111011;  // din[1] = 1,1,0,1,1,1
        tgl_level = 1'b1;
        v = d3[1];
        for (int n = 0; n < 6; n++) begin
            din = {2'b00, seq_v[n], 1'b0};
            tick();
            checks++;
            if (n < 5 && (d3[1] !== v || p3[1] !== 1'b0)) begin
                $display("FAIL hold_early step%0d dout1=%b pulse1=%b exp %b 0", n, d3[1], p3[1], v); errors++;
            end else if (n == 5 && (d3[1] !== ~v || p3[1] !== 1'b1)) begin
                $display("FAIL hold_toggle dout1=%b pulse1=%b exp %b 1", d3[1], p3[1], ~v); errors++;
            end
        end
        din = 4'b0000;
        tick();
        checks++;
        if (p3[1] !== 1'b0 || obs_s !== exp_all()) begin
            $display("FAIL hold_pulse_end pulse1=%b obs=%h exp=%h", p3[1], obs_s, exp_all()); errors++;
        end
    endtask

    task automatic test_freeze();
        logic v;
        tgl_level = 1'b1;
        v = d3[1];
        din = 4'b0010;
        tick(); tick();
        en = 1'b0;
        for (int n = 0; n < 4; n++) begin
            din = 4'($urandom_range(0, 15));
            tick();
        end
        checks++;
        if (d3[1] !== v) begin
            $display("FAIL freeze_hold dout1=%b exp %b", d3[1], v); errors++;
        end
        en = 1'b1;
        din = 4'b0010;
        tick();
        checks++;
        if (d3[1] !== ~v || p3[1] !== 1'b1) begin
            $display("FAIL freeze_resume dout1=%b pulse1=%b exp %b 1", d3[1], p3[1], ~v); errors++;
        end
        checks++;
        if (obs_s !== exp_all()) begin
            $display("FAIL freeze_model obs=%h exp=%h", obs_s, exp_all()); errors++;
        end
    endtask

    task automatic test_saturation();
        logic v;
        tgl_level = 1'b0;
        din = 4'b1111;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (cs !== 8'h00 || c1 !== 32'h0) begin
            $display("FAIL sat_clear cs=%h c1=%h exp 0", cs, c1); errors++;
        end
        din = 4'b1011;
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (cs[5:4] !== 2'd3 || c1[23:16] !== 8'd5) begin
            $display("FAIL sat_stick cs2=%0d c1_2=%0d exp 3 5", cs[5:4], c1[23:16]); errors++;
        end
        v = ds[2];
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (cs[5:4] !== 2'd0 || ds[2] !== ~v || ps[2] !== 1'b1) begin
            $display("FAIL sat_clr_priority cs2=%0d dout2=%b pulse2=%b exp 0 %b 1", cs[5:4], ds[2], ps[2], ~v); errors++;
        end
        checks++;
        if (obs_s !== exp_all()) begin
            $display("FAIL sat_model obs=%h exp=%h", obs_s, exp_all()); errors++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en        = ($urandom_range(0, 7) != 0);
            tgl_level = ($urandom_range(0, 15) == 0) ? ~tgl_level : tgl_level;
            din       = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) din = {4{~tgl_level}} ^ 4'($urandom_range(0, 15) & 1);
            cnt_clr   = ($urandom_range(0, 40) == 0);
            tick();
            checks++;
            if (obs_s !== exp_all()) begin
                $display("FAIL random cyc%0d obs=%h exp=%h", n, obs_s, exp_all()); errors++;
            end
        end
        en = 1'b1; cnt_clr = 1'b0;
    endtask

    task automatic test_async_mid();
        logic [95:0] rst_exp;
        rst_exp = {4'hF, 4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 4'hF, 4'h0, 8'h0};
        en = 1'b1; tgl_level = 1'b0;
        din = 4'b1111;
        tick();
        din = 4'b0000;
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs_s !== rst_exp) begin
            $display("FAIL async_mid obs=%h exp=%h", obs_s, rst_exp); errors++;
        end
        #2;
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (n < 2 && d3 !== 4'h0) begin
                $display("FAIL async_restart step%0d dout=%b exp 0000", n, d3); errors++;
            end else if (n == 2 && (d3 !== 4'hF || p3 !== 4'hF)) begin
                $display("FAIL async_toggle dout=%b pulse=%b exp 1111 1111", d3, p3); errors++;
            end
            checks++;
            if (obs_s !== exp_all()) begin
                $display("FAIL async_model step%0d obs=%h exp=%h", n, obs_s, exp_all()); errors++;
            end
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; tgl_level = 1'b0; din = 4'b0000; cnt_clr = 1'b0;
        model_reset();
        test_reset();
        test_legacy();
        test_hold();
        test_freeze();
        test_saturation();
        test_random();
        test_async_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
